// File: rtl/dac_sample_pacer.sv
// Buffers 32-bit bus words and plays them out as 10-bit DAC samples at a programmable rate.
// Define DAC_PACER_PACKED_EN to play two samples per word (bits [6:15], then [22:31]); the default plays one sample per word from [22:31].
module dac_sample_pacer #(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic             Bus2IP_Clk,
    input  logic             Bus2IP_Reset,
    input  logic [0:31]      Wr_Data,
    input  logic             Wr_Valid,
    output logic             Wr_Ready,
    input  logic             Enable,
    input  logic [0:15]      Rate_Div,
    input  logic             Underrun_Clr,
    output logic [0:9]       Sample_Data,
    output logic             Sample_Strobe,
    output logic [0:LVL_W-1] Fifo_Level,
    output logic             Underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef DAC_PACER_PACKED_EN
    localparam int DW = 20;
`else
    localparam int DW = 10;
`endif

    typedef enum logic {HI = 1'b0, LO = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [9:0]         sample_q, sample_d;
    logic               strobe_q, strobe_d;
    logic               underrun_q, underrun_d;
    logic [DW-1:0]      mem_q [FIFO_DEPTH];

    logic               full, empty, tick, push, pop;
    logic [DW-1:0]      wr_word, head;
    logic               unused_bits;

    // Only the sample fields are stored; the pad bits never reach the buffer.
`ifdef DAC_PACER_PACKED_EN
    assign wr_word     = {Wr_Data[6:15], Wr_Data[22:31]};
    assign unused_bits = ^{Wr_Data[0:5], Wr_Data[16:21]};
`else
    assign wr_word     = Wr_Data[22:31];
    assign unused_bits = ^Wr_Data[0:21];
`endif

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign tick  = Enable && (cnt_q == Rate_Div);
    assign push  = Wr_Valid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        strobe_d   = 1'b0;
        pop        = 1'b0;
        underrun_d = underrun_q && !Underrun_Clr;

        if (!Enable)
            cnt_d = '0;
        else if (cnt_q == Rate_Div)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 16'd1;

        // LO is only entered with a word at the head, so an LO tick never sees an empty buffer.
        if (tick) begin
            if (state_q == HI && empty) begin
                underrun_d = 1'b1;
            end else begin
`ifdef DAC_PACER_PACKED_EN
                if (state_q == HI) begin
                    sample_d = head[19:10];
                    state_d  = LO;
                end else begin
                    sample_d = head[9:0];
                    pop      = 1'b1;
                    state_d  = HI;
                end
`else
                sample_d = head[9:0];
                pop      = 1'b1;
`endif
                strobe_d = 1'b1;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q    <= HI;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sample_q   <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (push && !Bus2IP_Reset)
            mem_q[wr_ptr_q] <= wr_word;
    end

    assign Wr_Ready      = !full;
    assign Sample_Data   = sample_q;
    assign Sample_Strobe = strobe_q;
    assign Fifo_Level    = level_q;
    assign Underrun      = underrun_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer; expectations follow the DAC_PACER_PACKED_EN setting of the build.
module tb_dac_sample_pacer;

`ifdef DAC_PACER_PACKED_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:31] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        enable = 1'b0;
    logic [0:15] rate_div = '0;
    logic        und_clr = 1'b0;
    logic [0:9]  sample_data;
    logic        sample_strobe;
    logic [0:4]  fifo_level;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dac_sample_pacer #(.FIFO_DEPTH(16), .LVL_W(5)) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .Wr_Data      (wr_data),
        .Wr_Valid     (wr_valid),
        .Wr_Ready     (wr_ready),
        .Enable       (enable),
        .Rate_Div     (rate_div),
        .Underrun_Clr (und_clr),
        .Sample_Data  (sample_data),
        .Sample_Strobe(sample_strobe),
        .Fifo_Level   (fifo_level),
        .Underrun     (underrun)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string tag, input int max, output logic [9:0] d, output int c);
        c = 0;
        d = '0;
        do begin
            step();
            c++;
        end while (!sample_strobe && c < max);
        if (sample_strobe)
            d = sample_data;
        else
            check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [9:0] hi_s(input int i);
        return 10'(i * 37 + 5);
    endfunction

    function automatic logic [9:0] lo_s(input int i);
        return 10'(i * 53 + 700);
    endfunction

    // Pad fields carry junk so that ignoring them is exercised.
    function automatic logic [31:0] mk(input int i);
        return {6'h3F, hi_s(i), 6'h2A, lo_s(i)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] d;
        logic [9:0] exp_d;
        int c;
        int cnt;

        do_reset();
        #1;
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ready", 32'(wr_ready), 1);
        check("rst_sample", 32'(sample_data), 0);
        check("rst_strobe", 32'(sample_strobe), 0);
        check("rst_underrun", 32'(underrun), 0);

        // Basic playback at period 4
        rate_div = 16'd3;
        wr_data  = 32'h0155_02AA;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("basic_level1", 32'(fifo_level), 1);
        enable = 1'b1;
        wait_strobe("basic_s1", 10, d, c);
        check("basic_s1_cyc", c, 4);
        check("basic_s1_dat", 32'(d), PK ? 32'h155 : 32'h2AA);
        if (PK) begin
            check("basic_level_mid", 32'(fifo_level), 1);
            wait_strobe("basic_s2", 10, d, c);
            check("basic_s2_cyc", c, 4);
            check("basic_s2_dat", 32'(d), 32'h2AA);
        end
        enable = 1'b0;
        check("basic_level0", 32'(fifo_level), 0);

        // Fill to full while paused, then overflow attempt
        for (int i = 0; i < 16; i++) begin
            wr_data  = mk(i);
            wr_valid = 1'b1;
            step();
        end
        check("full_level", 32'(fifo_level), 16);
        check("full_ready", 32'(wr_ready), 0);
        wr_data = 32'hFFFF_FFFF;
        step();
        wr_valid = 1'b0;
        check("full_ignored", 32'(fifo_level), 16);

        // Drain at one sample per clock
        rate_div = 16'd0;
        enable   = 1'b1;
        exp_d    = '0;
        for (int k = 0; k < (PK ? 32 : 16); k++) begin
            if (PK)
                exp_d = (k % 2 == 0) ? hi_s(k / 2) : lo_s(k / 2);
            else
                exp_d = lo_s(k);
            wait_strobe("drain", 3, d, c);
            check($sformatf("drain_dat%0d", k), 32'(d), 32'(exp_d));
            check($sformatf("drain_cyc%0d", k), c, 1);
        end
        check("drain_level", 32'(fifo_level), 0);
        check("drain_no_und", 32'(underrun), 0);
        step();
        check("und_set", 32'(underrun), 1);
        check("und_no_strobe", 32'(sample_strobe), 0);
        check("und_hold", 32'(sample_data), 32'(exp_d));

        // Clear racing a fresh underrun, then clear with data present
        und_clr = 1'b1;
        step();
        check("clr_race", 32'(underrun), 1);
        und_clr  = 1'b0;
        enable   = 1'b0;
        wr_data  = 32'h0001_0002;
        wr_valid = 1'b1;
        step();
        wr_data = 32'h0003_0004;
        step();
        wr_valid = 1'b0;
        und_clr  = 1'b1;
        step();
        check("clr_ok", 32'(underrun), 0);
        und_clr = 1'b0;

        // Pause mid-word, then resume
        rate_div = 16'd3;
        enable   = 1'b1;
        wait_strobe("pause_s1", 10, d, c);
        check("pause_s1_dat", 32'(d), PK ? 32'h001 : 32'h002);
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (sample_strobe) cnt++;
        end
        check("pause_no_strobe", cnt, 0);
        check("pause_level", 32'(fifo_level), PK ? 2 : 1);
        enable = 1'b1;
        wait_strobe("pause_s2", 10, d, c);
        check("pause_s2_cyc", c, 4);
        check("pause_s2_dat", 32'(d), PK ? 32'h002 : 32'h004);
        enable = 1'b0;

        // Reset mid-playback dominates writes and ticks
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_data  = mk(i);
            wr_valid = 1'b1;
            step();
        end
        wr_valid = 1'b0;
        rate_div = 16'd0;
        enable   = 1'b1;
        step();
        check("mid_strobe", 32'(sample_strobe), 1);
        check("mid_dat", 32'(sample_data), PK ? 32'(hi_s(0)) : 32'(lo_s(0)));
        rst      = 1'b1;
        wr_data  = mk(9);
        wr_valid = 1'b1;
        step();
        check("mid_rst_level", 32'(fifo_level), 0);
        check("mid_rst_ready", 32'(wr_ready), 1);
        check("mid_rst_sample", 32'(sample_data), 0);
        check("mid_rst_strobe", 32'(sample_strobe), 0);
        check("mid_rst_underrun", 32'(underrun), 0);
        rst     = 1'b0;
        enable  = 1'b0;
        wr_data = 32'h00AB_00CD;
        step();
        wr_valid = 1'b0;
        check("post_rst_level", 32'(fifo_level), 1);
        enable = 1'b1;
        wait_strobe("post_rst", 4, d, c);
        check("post_rst_cyc", c, 1);
        check("post_rst_dat", 32'(d), PK ? 32'h0AB : 32'h0CD);
        enable = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_sample_pacer.md
DAC_SAMPLE_PACER -- requirements
Module: dac_sample_pacer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of 32-bit words buffered (power of two, 4..64).
REQ-002 SHALL have parameter LVL_W, default 5, width of Fifo_Level; equals log2(FIFO_DEPTH)+1.
REQ-003 SHALL have port Bus2IP_Clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port Bus2IP_Reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port Wr_Data  in  [0:31]  packed sample word from bus write path.
REQ-006 SHALL have port Wr_Valid  in  1  Wr_Data valid this cycle.
REQ-007 SHALL have port Wr_Ready  out  1  FIFO can accept a word.
REQ-008 SHALL have port Enable  in  1  playback enable.
REQ-009 SHALL have port Rate_Div  in  [0:15]  sample period minus one, in clocks.
REQ-010 SHALL have port Underrun_Clr  in  1  clears Underrun.
REQ-011 SHALL have port Sample_Data  out  [0:9]  current sample to DAC driver.
REQ-012 SHALL have port Sample_Strobe  out  1  one-cycle pulse when Sample_Data updates.
REQ-013 SHALL have port Fifo_Level  out  [0:LVL_W-1]  words held.
REQ-014 SHALL have port Underrun  out  1  sticky: tick occurred with no sample available.

Function
REQ-015 Write SHALL be accepted on any edge where Wr_Valid and Wr_Ready are both 1; Wr_Ready SHALL equal not-full, with no same-cycle bypass from a pop.
REQ-016 Accepted word SHALL be poppable from the next cycle; Fifo_Level SHALL update on the accepting edge (push + pop same edge: level unchanged).
REQ-017 Pace counter SHALL count 0..Rate_Div and wrap to 0; tick SHALL occur on the edge where counter equals Rate_Div and Enable=1; Rate_Div=0 gives a tick every cycle.
REQ-018 Enable=0 SHALL hold counter at 0 and suppress ticks; a half-consumed word and the HI/LO state SHALL be retained.
REQ-019 Unpacker state machine SHALL have states HI and LO; reset state HI.
REQ-020 On a tick in HI with FIFO non-empty: Sample_Data <= head[6:15], Sample_Strobe=1 next cycle, state -> LO, no pop.
REQ-021 On a tick in LO: Sample_Data <= head[22:31], pop head, Sample_Strobe=1, state -> HI.
REQ-022 On a tick in HI with FIFO empty: Underrun <= 1, Sample_Data held, no strobe, state stays HI.
REQ-023 Sample_Data and Sample_Strobe SHALL be registered; strobe asserted exactly the cycle after the tick edge's evaluation, i.e. same edge as Sample_Data change.
REQ-024 Underrun_Clr=1 SHALL clear Underrun next edge; simultaneous new underrun SHALL win (flag stays 1).
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; writes at full SHALL be ignored with no corruption.
REQ-026 Bits [0:5] and [16:21] of Wr_Data SHALL be ignored.

Reset
REQ-027 Bus2IP_Reset=1 SHALL on the next edge set: FIFO empty, Fifo_Level=0, Wr_Ready=1, counter=0, state HI, Sample_Data=0, Sample_Strobe=0, Underrun=0.
REQ-028 Reset mid-playback SHALL discard all buffered words and any half-consumed word; reset SHALL dominate every other input.

Configuration
REQ-029 Macro DAC_PACER_PACKED_EN defined: two samples per word per REQ-020/021.
REQ-030 DAC_PACER_PACKED_EN undefined: one sample per word from [22:31]; every successful tick pops; state machine stays HI; empty tick behaves per REQ-022.

Verification
REQ-031 Reset, write 32'h0155_02AA, Enable=1, Rate_Div=3 -> strobes 4 clocks apart, Sample_Data 10'h155 then 10'h2AA, Fifo_Level 1->0 after second.
REQ-032 Write 16 words with Enable=0 -> Fifo_Level=16, Wr_Ready=0; 17th write ignored; playback yields exactly 32 samples (packed) in order.
REQ-033 Rate_Div=0, FIFO drains -> strobe every cycle, then Underrun=1 on first empty tick, Sample_Data holds last value.
REQ-034 Underrun_Clr coincident with new empty tick -> Underrun remains 1; clear with FIFO non-empty -> Underrun=0.
REQ-035 Enable dropped after HI sample of 32'h0001_0002 -> no strobes while low; re-enable -> next sample 10'h002.
REQ-036 Reset asserted with 5 words buffered in LO state -> all outputs at REQ-027 values next cycle; next write plays from HI.
